// File: rtl/bounce_scan_ctrl.sv
// bounce_scan_ctrl: sequencer for the bouncing one-hot shift register.
// Emits the prescaled shift-enable strobe and counts terminal-count pulses per sweep.
module bounce_scan_ctrl #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstna,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [DIV_W-1:0] div_val,
  input  logic [CNT_W-1:0] n_periods,
  input  logic             tc_in,
  output logic             sr_ena,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] period_cnt,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div_q;
  logic [DIV_W-1:0] w_div_nxt;
  logic [DIV_W-1:0] r_pre_cnt;
  logic [DIV_W-1:0] w_pre_nxt;
  logic [CNT_W-1:0] r_tgt_q;
  logic [CNT_W-1:0] w_tgt_nxt;
  logic [CNT_W-1:0] r_period_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_tgt_hit;
  logic             r_sr_ena;
  logic             w_ena_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_aborted;
  logic             w_abort_nxt;

  assign w_cnt_inc = r_period_cnt + CNT_W'(1'b1);
  // A zero target means free-run: the counter wraps and never completes.
  assign w_tgt_hit = (r_tgt_q != {CNT_W{1'b0}}) && (w_cnt_inc == r_tgt_q);

  // Next-state and next-output decode; priority in a sweep is stop > completion > pause.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div_q;
    w_tgt_nxt   = r_tgt_q;
    w_pre_nxt   = r_pre_cnt;
    w_cnt_nxt   = r_period_cnt;
    w_ena_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_abort_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_state_nxt = ST_RUN;
          w_div_nxt   = div_val;
          w_tgt_nxt   = n_periods;
          w_pre_nxt   = {DIV_W{1'b0}};
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN, ST_PAUSE: begin
        if (tc_in) begin
          w_cnt_nxt = w_cnt_inc;
        end else begin
          w_cnt_nxt = r_period_cnt;
        end
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_abort_nxt = 1'b1;
        end else if (tc_in && w_tgt_hit) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else if (pause) begin
          w_state_nxt = ST_PAUSE;
        end else begin
          // Prescaler only advances on unpaused cycles, so a pause stretches the gap exactly.
          w_state_nxt = ST_RUN;
          if (r_pre_cnt == r_div_q) begin
            w_pre_nxt = {DIV_W{1'b0}};
            w_ena_nxt = 1'b1;
          end else begin
            w_pre_nxt = r_pre_cnt + DIV_W'(1'b1);
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSE);
  end

  // State register
  always_ff @(posedge clk or negedge rstna) begin
    if (!rstna) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Captured sweep settings, counters and registered outputs
  always_ff @(posedge clk or negedge rstna) begin
    if (!rstna) begin
      r_div_q      <= {DIV_W{1'b0}};
      r_tgt_q      <= {CNT_W{1'b0}};
      r_pre_cnt    <= {DIV_W{1'b0}};
      r_period_cnt <= {CNT_W{1'b0}};
      r_sr_ena     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_div_q      <= w_div_nxt;
      r_tgt_q      <= w_tgt_nxt;
      r_pre_cnt    <= w_pre_nxt;
      r_period_cnt <= w_cnt_nxt;
      r_sr_ena     <= w_ena_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_aborted    <= w_abort_nxt;
    end
  end

  assign sr_ena     = r_sr_ena;
  assign busy       = r_busy;
  assign done       = r_done;
  assign aborted    = r_aborted;
  assign period_cnt = r_period_cnt;
  assign state_o    = r_state;

endmodule

// File: tb/tb_bounce_scan_ctrl.sv
// Self-checking bench for bounce_scan_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a sweep-level reference model.
module tb_bounce_scan_ctrl;
  localparam int DIV_W = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rstna = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             pause = 1'b0;
  logic             tc_in = 1'b0;
  logic [DIV_W-1:0] div_val = '0;
  logic [CNT_W-1:0] n_periods = '0;
  logic             sr_ena;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] period_cnt;
  logic [1:0]       state_o;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: mode 0 idle, 1 run, 2 pause, 3 done; m_adv counts unpaused sweep cycles.
  int   m_mode = 0;
  int   m_div = 0;
  int   m_tgt = 0;
  int   m_adv = 0;
  int   m_cnt = 0;
  logic e_ena = 1'b0;
  logic e_busy = 1'b0;
  logic e_done = 1'b0;
  logic e_abort = 1'b0;
  logic [13:0] e_vec = '0;
  wire  [13:0] dut_vec = {sr_ena, busy, done, aborted, period_cnt, state_o};

  always #5 clk = ~clk;

  bounce_scan_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstna(rstna), .start(start), .stop(stop), .pause(pause),
    .div_val(div_val), .n_periods(n_periods), .tc_in(tc_in),
    .sr_ena(sr_ena), .busy(busy), .done(done), .aborted(aborted),
    .period_cnt(period_cnt), .state_o(state_o)
  );

  // Predict the outputs after the coming edge from the current inputs, then clock.
  task automatic step();
    int nm;
    e_ena = 1'b0; e_done = 1'b0; e_abort = 1'b0;
    nm = m_mode;
    if (!rstna) begin
      nm = 0; m_cnt = 0; m_adv = 0; m_div = 0; m_tgt = 0;
    end else if (m_mode == 1 || m_mode == 2) begin
      if (tc_in) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (stop) begin
        nm = 0; e_abort = 1'b1;
      end else if (tc_in && m_tgt != 0 && m_cnt == m_tgt) begin
        nm = 3; e_done = 1'b1;
      end else if (pause) begin
        nm = 2;
      end else begin
        nm = 1; m_adv++;
        e_ena = ((m_adv % (m_div + 1)) == 0);
      end
    end else if (m_mode == 0 && start && !stop) begin
      nm = 1; m_div = int'(div_val); m_tgt = int'(n_periods); m_adv = 0; m_cnt = 0;
    end else begin
      nm = 0;
    end
    e_busy = (nm == 1 || nm == 2);
    e_vec = {e_ena, e_busy, e_done, e_abort, CNT_W'(m_cnt), 2'(nm)};
    @(posedge clk); #1;
    cyc++;
    m_mode = nm;
  endtask

  task automatic test_reset();
    rstna = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; tc_in = 1'b0;
    repeat (4) begin
      step();
      vectors++;
      if (dut_vec !== e_vec) begin
        errors++; $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, dut_vec, e_vec);
      end
    end
    @(negedge clk); rstna = 1'b1;
    repeat (20) begin
      step();
      vectors++;
      if (dut_vec !== e_vec) begin
        errors++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, dut_vec, e_vec);
      end
    end
  endtask

  task automatic test_count_done();
    int q = 0;
    int nstr = 0;
    int left = -1;
    int r_cyc;
    int first_str = -1;
    logic done_seen = 1'b0;
    div_val = 16'd3; n_periods = 8'd2; start = 1'b1; stop = 1'b0; pause = 1'b0; tc_in = 1'b0;
    step();
    vectors++;
    if (dut_vec !== e_vec) begin
      errors++; $display("FAIL count_start cyc=%0d got=%h exp=%h", cyc, dut_vec, e_vec);
    end
    r_cyc = cyc;
    start = 1'b0;
    for (int i = 0; i < 300 && left != 0; i++) begin
      div_val = DIV_W'($urandom); n_periods = CNT_W'($urandom);
      tc_in = (q == 1);
      if (q > 0) q--;
      step();
      vectors++;
      if (dut_vec !== e_vec) begin
        errors++; $display("FAIL count_done cyc=%0d got=%h exp=%h", cyc, dut_vec, e_vec);
      end
      if (sr_ena === 1'b1 && first_str < 0) first_str = cyc;
      if (done === 1'b1) done_seen = 1'b1;
      if (e_ena) begin
        nstr++;
        if (nstr % 8 == 0) q = 2;
      end
      if (e_done) left = 4;
      else if (left > 0) left--;
    end
    tc_in = 1'b0;
    vectors++;
    if (first_str - r_cyc !== 4) begin
      errors++; $display("FAIL first_strobe got=R+%0d exp=R+4", first_str - r_cyc);
    end
    vectors++;
    if (done_seen !== 1'b1) begin
      errors++; $display("FAIL done_timeout got=%b exp=1", done_seen);
    end
    vectors++;
    if (period_cnt !== 8'd2 || state_o !== 2'd0) begin
      errors++; $display("FAIL count_hold got cnt=%0d st=%0d exp cnt=2 st=0", period_cnt, state_o);
    end
  endtask

  task automatic test_free_run();
    div_val = 16'd0; n_periods = 8'd0; start = 1'b1;
    step();
    start = 1'b0; tc_in = 1'b1;
    for (int i = 0; i < 257; i++) begin
      step();
      vectors++;
      if (dut_vec !== e_vec) begin
        errors++; $display("FAIL free_run cyc=%0d got=%h exp=%h", cyc, dut_vec, e_vec);
      end
    end
    tc_in = 1'b0;
    vectors++;
    if (period_cnt !== 8'd1 || sr_ena !== 1'b1) begin
      errors++; $display("FAIL free_wrap got cnt=%0d ena=%b exp cnt=1 ena=1", period_cnt, sr_ena);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (3) begin
      vectors++;
      if (dut_vec !== e_vec) begin
        errors++; $display("FAIL free_stop cyc=%0d got=%h exp=%h", cyc, dut_vec, e_vec);
      end
      step();
    end
  endtask

  task automatic test_pause();
    int nstr = 0;
    int last_str = 0;
    int next_str = -1;
    div_val = 16'd4; n_periods = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 30 && nstr < 2; i++) begin
      step();
      vectors++;
      if (dut_vec !== e_vec) begin
        errors++; $display("FAIL pause_pre cyc=%0d got=%h exp=%h", cyc, dut_vec, e_vec);
      end
      if (sr_ena === 1'b1) begin nstr++; last_str = cyc; end
    end
    for (int i = 0; i < 42 && next_str < 0; i++) begin
      pause = (i >= 2 && i < 12);
      step();
      vectors++;
      if (dut_vec !== e_vec) begin
        errors++; $display("FAIL pause_run cyc=%0d got=%h exp=%h", cyc, dut_vec, e_vec);
      end
      if (sr_ena === 1'b1) next_str = cyc;
    end
    pause = 1'b0;
    vectors++;
    if (next_str - last_str !== 15) begin
      errors++; $display("FAIL pause_spacing got=%0d exp=15", next_str - last_str);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  task automatic test_stop_tc();
    logic done_seen = 1'b0;
    div_val = DIV_W'($urandom_range(0, 5)); n_periods = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      stop = (i == 3); tc_in = (i == 3);
      step();
      vectors++;
      if (dut_vec !== e_vec) begin
        errors++; $display("FAIL stop_tc cyc=%0d got=%h exp=%h", cyc, dut_vec, e_vec);
      end
      if (done === 1'b1) done_seen = 1'b1;
    end
    stop = 1'b0; tc_in = 1'b0;
    vectors++;
    if (period_cnt !== 8'd1 || done_seen !== 1'b0) begin
      errors++; $display("FAIL stop_tc_final got cnt=%0d done=%b exp cnt=1 done=0", period_cnt, done_seen);
    end
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    vectors++;
    if (dut_vec !== e_vec || state_o !== 2'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL start_stop_idle got=%h exp=%h", dut_vec, e_vec);
    end
  endtask

  task automatic test_async_reset();
    div_val = 16'd3; n_periods = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    #3 rstna = 1'b0;
    m_mode = 0; m_cnt = 0; m_adv = 0; m_div = 0; m_tgt = 0;
    e_vec = '0;
    #2;
    vectors++;
    if (dut_vec !== e_vec) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", dut_vec, e_vec);
    end
    #1 rstna = 1'b1;
    step();
    vectors++;
    if (dut_vec !== e_vec) begin
      errors++; $display("FAIL async_release got=%h exp=%h", dut_vec, e_vec);
    end
    test_count_done();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 5) == 0);
      stop = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      tc_in = ($urandom_range(0, 7) == 0);
      div_val = DIV_W'($urandom_range(0, 5));
      n_periods = CNT_W'($urandom_range(0, 3));
      step();
      vectors++;
      if (dut_vec !== e_vec) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, e_vec);
      end
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0; tc_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_done();
    test_free_run();
    test_pause();
    test_stop_tc();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/bounce_scan_ctrl.md
Name: bounce_scan_ctrl

Overview:
Sequencer for the bouncing one-hot shift register. It produces the register's shift-enable strobe from a programmable prescaler and counts the register's terminal-count (TC) pulses. It stops the sweep after a programmed number of bounce periods, or runs freely until stopped. It sits between the control/register interface (start/stop/pause, speed, period target) and the shift register's ena/TC pins.

Parameters:
DIV_W, 16, width of the prescaler divide value and counter
CNT_W, 8, width of the period target and period counter

Ports:
clk  in  1  clock
rstna  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to begin a sweep; sampled only in IDLE
stop  in  1  single-cycle abort request; acted on in RUN/PAUSE
pause  in  1  level; while high in RUN, strobes are frozen
div_val  in  DIV_W  strobe period minus one, captured at start
n_periods  in  CNT_W  number of TC pulses to complete; 0 = free-run; captured at start
tc_in  in  1  TC pulse from the shift register
sr_ena  out  1  registered shift-enable strobe to the shift register
busy  out  1  high in RUN and PAUSE
done  out  1  one-cycle pulse on normal completion
aborted  out  1  one-cycle pulse on stop-initiated exit
period_cnt  out  CNT_W  TC pulses counted in the current/last sweep
state_o  out  2  encoded state: IDLE=0, RUN=1, PAUSE=2, DONE=3

Behaviour:
- Reset (rstna low, async): state=IDLE; sr_ena=0, busy=0, done=0, aborted=0, period_cnt=0; internal div_q, tgt_q, pre_cnt cleared. Reset mid-sweep aborts without an aborted pulse.
- IDLE:
  - When start=1 and stop=0: latch div_q<=div_val, tgt_q<=n_periods, pre_cnt<=0, period_cnt<=0; next state RUN.
  - When start and stop are both high: stop wins; stay in IDLE with no pulses.
  - tc_in is ignored.
- RUN (first RUN cycle = R):
  - pre_cnt increments each RUN cycle and wraps to 0 when pre_cnt==div_q.
  - sr_ena is registered high for exactly the cycle after the wrap. The first strobe is at R+div_q+1; later strobes follow every div_q+1 cycles.
  - div_q=0 gives sr_ena continuously high from R+1.
  - busy=1.
- PAUSE:
  - Entered from RUN when pause=1. pre_cnt holds its value and no new sr_ena is issued. A strobe already registered from the last RUN cycle still completes.
  - Returns to RUN when pause=0; pre_cnt resumes from its held value.
  - busy=1.
- TC counting:
  - tc_in=1 in RUN or PAUSE increments period_cnt (mod 2^CNT_W).
  - If tgt_q!=0 and period_cnt+1==tgt_q, next state is DONE. Completion takes priority over pause in the same cycle.
  - With tgt_q=0 (free-run), period_cnt wraps 2^CNT_W-1 -> 0 and never completes.
- DONE: lasts one cycle. done=1, busy=0, sr_ena=0; next state IDLE. start in DONE is ignored.
- stop=1 in RUN or PAUSE:
  - Next state IDLE; aborted=1 for one cycle (the first IDLE cycle); sr_ena forced 0 next cycle.
  - A tc_in in the same cycle is still counted, but done is not asserted. stop has priority over completion.
- start while busy is ignored; div_val and n_periods may change mid-sweep with no effect.
- period_cnt holds its final value in IDLE until the next accepted start.
- done and aborted are never both high in the same cycle.

Test Plan:
- Reset: hold rstna=0 with clk running, then release -> all outputs 0, state_o=0, no sr_ena for 20 cycles.
- div_val=3, n_periods=2, pulse start; a bench model drives tc_in one cycle after every 8th sr_ena -> sr_ena every 4 cycles starting at R+4; period_cnt 1 then 2; done pulse one cycle after the 2nd TC; busy falls with done; period_cnt holds 2.
- div_val=0, n_periods=0, start; force 257 TC pulses -> sr_ena high every RUN cycle; period_cnt reaches 255 then wraps to 0, then 1; no done; stop -> aborted pulse, IDLE.
- div_val=4: assert pause for 10 cycles mid-count -> no sr_ena during pause; after release, next strobe arrives after the remaining prescale count (strobe spacing = 5 + 10 cycles across the pause).
- n_periods=1: drive stop and tc_in in the same cycle -> period_cnt=1, aborted=1, done never asserted; start+stop together in IDLE -> remains IDLE.
- Mid-RUN: assert rstna low asynchronously (not clock-aligned) -> outputs clear immediately with no aborted pulse; a fresh start afterwards behaves as in the div_val=3 scenario.
